shift_seq_ctrl: RTL
===================

Name: shift_seq_ctrl

Overview:
Command-driven sequencer for the bidirectional shift register datapath.
- Accepts LOAD, SHIFT-LEFT-N, SHIFT-RIGHT-N and NOP commands over a valid/ready handshake.
- Drives the datapath control lines (en, load, left, right) cycle by cycle.
- Reports completion with a one-cycle done pulse carrying the datapath's q value.
- Sits between the host/test logic and one bidirect_shift instance.

Parameters:
WIDTH, 4, datapath width (load/q bits).
CNT_W, 3, width of shift-count field; max count 2^CNT_W-1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command.
cmd_op  input  2  00=NOP, 01=LOAD, 10=SHL, 11=SHR.
cmd_cnt  input  CNT_W  shift count for SHL/SHR; ignored otherwise.
cmd_data  input  WIDTH  load value for LOAD; ignored otherwise.
abort  input  1  synchronous abort of the in-flight command.
sr_en  output  1  to datapath en: parallel load this cycle.
sr_load  output  WIDTH  to datapath load bus.
sr_left  output  1  to datapath left: shift left one bit this cycle, zero fill.
sr_right  output  1  to datapath right: shift right one bit this cycle, zero fill.
sr_q  input  WIDTH  from datapath q.
done  output  1  one-cycle completion pulse.
done_abort  output  1  high with done when the command was aborted.
result  output  WIDTH  sr_q when done=1, else 0 (combinational).

Behaviour:
- Reset (rst=0, async): state=IDLE. sr_en=sr_left=sr_right=0, sr_load=0, done=done_abort=0, count=0. Outputs are held while rst=0.
- States: IDLE, LOAD, SHIFT, DONE. All control outputs are registered.
- cmd_ready=1 only in IDLE. A command is accepted on a rising edge with cmd_valid&&cmd_ready. op/cnt/data are latched on accept.
- IDLE to next state on accept:
  - NOP goes to DONE.
  - LOAD goes to LOAD.
  - SHL/SHR with cnt>0 goes to SHIFT.
  - SHL/SHR with cnt=0 goes to DONE with no datapath activity.
- LOAD: sr_en=1 and sr_load=latched data for exactly one cycle, then DONE.
- SHIFT: sr_left (SHL) or sr_right (SHR) is high for exactly cnt consecutive cycles, then DONE. The internal counter decrements once per shift cycle.
- DONE: done=1 for one cycle. result=sr_q, which already reflects the final load/shift edge. Then IDLE.
- Mutual exclusion: at most one of sr_en, sr_left, sr_right is high in any cycle; all are low in IDLE and DONE. sr_load=0 outside LOAD.
- Latency, with accept at edge k:
  - NOP: done in cycle k+1.
  - LOAD: sr_en in cycle k+1, done in cycle k+2.
  - SHL/SHR N (N>0): shift in cycles k+1..k+N, done in cycle k+N+1.
- Counts above WIDTH are legal; the register drains to all zeros.
- abort while in LOAD or SHIFT: the next state is DONE. Control outputs drop in the cycle after abort is sampled. That DONE cycle has done=1 and done_abort=1; shifts already applied are not undone.
- abort in IDLE or DONE is ignored.
- abort and cmd_valid together in IDLE: the command is accepted and abort is ignored.
- cmd_valid while busy: held off (cmd_ready=0). The command must stay stable until accepted.
- Back-to-back: a new command may be accepted in the IDLE cycle immediately after DONE. One idle cycle is the minimum gap between commands.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The datapath stops shifting; no done is issued.

Optional Feature:
SHIFT_SEQ_CTRL_BUSYCNT_EN
- Defined: adds output busy_cycles[15:0]. It counts cycles spent in LOAD or SHIFT, saturates at 16'hFFFF, and resets to 0 by rst.
- Not defined: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Reset with rst=0 for 2 cycles, then rst=1 -> all outputs 0, cmd_ready=1.
- LOAD data=4'b1010 -> sr_en=1 for 1 cycle with sr_load=1010; next cycle done=1, result=1010.
- After load 1010, SHL cnt=1 -> sr_left high 1 cycle, done with result=0100. Then SHR cnt=2 -> sr_right high 2 cycles, result=0001.
- After load 1111, SHR cnt=7 -> 7 shift cycles, result=0000. Then SHL cnt=0 -> done one cycle after accept, no sr_left, result=0000.
- After load 1010, SHL cnt=5 with abort asserted in the 2nd shift cycle -> exactly 2 shifts, done=1, done_abort=1, result=1000.
- During SHR cnt=3, drive rst=0 mid-shift -> sr_right drops immediately, no done. After release, cmd_ready=1 and LOAD 0110 completes normally.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving a bidirectional shift-register datapath (load / shift-left-N / shift-right-N / nop).
// Optional busy-cycle counter output enabled by defining SHIFT_SEQ_CTRL_BUSYCNT_EN.
module shift_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             abort,
   output logic             sr_en,
   output logic [WIDTH-1:0] sr_load,
   output logic             sr_left,
   output logic             sr_right,
   input  logic [WIDTH-1:0] sr_q,
   output logic             done,
   output logic             done_abort,
   output logic [WIDTH-1:0] result
`ifdef SHIFT_SEQ_CTRL_BUSYCNT_EN
   ,
   output logic [15:0]      busy_cycles
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE
   } state_t;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_SHL  = 2'b10;
   localparam logic [1:0] OP_SHR  = 2'b11;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   data_reg, data_next;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic               left_reg, left_next;
   logic               aborted_reg, aborted_next;

   logic               sr_en_reg, sr_en_next;
   logic [WIDTH-1:0]   sr_load_reg, sr_load_next;
   logic               sr_left_reg, sr_left_next;
   logic               sr_right_reg, sr_right_next;
   logic               done_reg, done_next;
   logic               done_abort_reg, done_abort_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         data_reg       <= '0;
         count_reg      <= '0;
         left_reg       <= 1'b0;
         aborted_reg    <= 1'b0;
         sr_en_reg      <= 1'b0;
         sr_load_reg    <= '0;
         sr_left_reg    <= 1'b0;
         sr_right_reg   <= 1'b0;
         done_reg       <= 1'b0;
         done_abort_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         data_reg       <= data_next;
         count_reg      <= count_next;
         left_reg       <= left_next;
         aborted_reg    <= aborted_next;
         sr_en_reg      <= sr_en_next;
         sr_load_reg    <= sr_load_next;
         sr_left_reg    <= sr_left_next;
         sr_right_reg   <= sr_right_next;
         done_reg       <= done_next;
         done_abort_reg <= done_abort_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      data_next    = data_reg;
      count_next   = count_reg;
      left_next    = left_reg;
      aborted_next = aborted_reg;

      case (state_reg)
         ST_IDLE: begin
            if (cmd_valid) begin
               data_next    = cmd_data;
               left_next    = (cmd_op == OP_SHL);
               aborted_next = 1'b0;
               count_next   = '0;
               case (cmd_op)
                  OP_NOP:  state_next = ST_DONE;
                  OP_LOAD: state_next = ST_LOAD;
                  default: begin
                     // A zero-count shift completes without touching the datapath.
                     if (cmd_cnt != '0) begin
                        state_next = ST_SHIFT;
                        count_next = cmd_cnt;
                     end else begin
                        state_next = ST_DONE;
                     end
                  end
               endcase
            end
         end
         ST_LOAD: begin
            state_next   = ST_DONE;
            aborted_next = abort;
         end
         ST_SHIFT: begin
            count_next = count_reg - CNT_W'(1);
            if (abort) begin
               state_next   = ST_DONE;
               aborted_next = 1'b1;
               count_next   = '0;
            end else if (count_reg == CNT_W'(1)) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Control lines are decoded from the next state so they appear registered.
      sr_en_next      = (state_next == ST_LOAD);
      sr_load_next    = (state_next == ST_LOAD) ? data_next : '0;
      sr_left_next    = (state_next == ST_SHIFT) && left_next;
      sr_right_next   = (state_next == ST_SHIFT) && !left_next;
      done_next       = (state_next == ST_DONE);
      done_abort_next = (state_next == ST_DONE) && aborted_next;
   end

   assign cmd_ready  = (state_reg == ST_IDLE);
   assign sr_en      = sr_en_reg;
   assign sr_load    = sr_load_reg;
   assign sr_left    = sr_left_reg;
   assign sr_right   = sr_right_reg;
   assign done       = done_reg;
   assign done_abort = done_abort_reg;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_result
         assign result[gi] = done_reg & sr_q[gi];
      end
   endgenerate

`ifdef SHIFT_SEQ_CTRL_BUSYCNT_EN
   logic [15:0] busy_cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_cnt_reg <= '0;
      end else if (((state_reg == ST_LOAD) || (state_reg == ST_SHIFT)) &&
                   (busy_cnt_reg != 16'hFFFF)) begin
         busy_cnt_reg <= busy_cnt_reg + 16'd1;
      end
   end

   assign busy_cycles = busy_cnt_reg;
`endif

endmodule
